z_norm_check: RTL and testbench
===============================

Z_NORM_CHECK -- requirements
Module: z_norm_check

Interface
REQ-001 SHALL have parameter L, default 7, polynomials per vector.
REQ-002 SHALL have parameter N, default 256, coefficients per polynomial.
REQ-003 SHALL have parameter GAMMA1, default 19; gamma1 = 2^GAMMA1.
REQ-004 SHALL have parameter BETA, default 120, norm margin.
REQ-005 SHALL have parameter Q, default 8380417, modulus.
REQ-006 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, begin pass; sampled only in IDLE.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have port done, output, 1, one-cycle pulse at pass end.
REQ-011 SHALL have port reject, output, 1, norm violation flag; held from done until next accepted start.
REQ-012 SHALL have port rd_addr, output, clog2(N*L) (11), shared read address to the y BRAM and the cs1 BRAM.
REQ-013 SHALL have port dout_y, input, 24, y coefficient, two's complement, range [-gamma1+1, gamma1].
REQ-014 SHALL have port dout_cs1, input, 23, c*s1 coefficient, range [0, Q-1].
REQ-015 SHALL have port we_z, output, 1, z BRAM write enable.
REQ-016 SHALL have port addr_z, output, 11, z write address.
REQ-017 SHALL have port din_z, output, 24, z coefficient, two's complement.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN, FIN.
REQ-019 SHALL move IDLE->RUN on start. In RUN, rd_addr SHALL be 0 in the first cycle and increment by 1 each cycle.
REQ-020 SHALL move RUN->DRAIN after issuing rd_addr = N*L-1.
REQ-021 SHALL move DRAIN->FIN when the write of the last issued index completes.
REQ-022 SHALL move FIN->IDLE after one cycle; done SHALL be 1 only in the FIN cycle.
REQ-023 SHALL treat both BRAMs as 1-cycle read latency: data for rd_addr presented in cycle k is valid on dout in cycle k+1.
REQ-024 SHALL register read data in one stage and assert we_z in the following cycle; an address issued in cycle k is written in cycle k+2 with addr_z equal to that address.
REQ-025 SHALL centre cs1: c = cs1 if cs1 <= (Q-1)/2, else cs1 - Q.
REQ-026 SHALL compute s = y + c in at least 25-bit signed arithmetic.
REQ-027 SHALL reduce s: z = s - Q if s > (Q-1)/2; z = s + Q if s < -(Q-1)/2; else z = s.
REQ-028 SHALL flag a violation when |z| >= gamma1 - BETA (524168 at defaults).
REQ-029 On a violation SHALL suppress we_z for that coefficient, set reject=1, stop issuing addresses, discard in-flight reads without writing them, and enter FIN the next cycle.
REQ-030 SHALL ignore start while busy.
REQ-031 SHALL clear reject when start is accepted.
REQ-032 SHALL make no more than N*L writes per pass and SHALL write strictly increasing addresses.
REQ-033 Outside a write cycle, we_z SHALL be 0; din_z and addr_z hold their last values.

Reset
REQ-034 On rst=1, SHALL set state=IDLE, busy=0, done=0, reject=0, rd_addr=0, we_z=0, addr_z=0, din_z=0 and clear the pipeline valid bits.
REQ-035 rst mid-pass SHALL abort with no further writes and no done pulse.
REQ-036 rst SHALL take priority over start in the same cycle.

Verification
REQ-037 Start sampled in cycle T, all y=0, cs1=0 -> 1792 writes of z=0 in cycles T+3..T+1794, addresses 0..1791; done pulses at T+1795; reject=0.
REQ-038 y[5]=524168, all other entries 0 -> writes only for addresses 0..4; no write to address 5 or later; done pulses; reject=1 and held.
REQ-039 y[i]=524167, cs1[i]=0 for all i -> every z=524167; reject=0. With y[i]=-524167, every z=-524167; reject=0.
REQ-040 y[0]=-524287, cs1[0]=Q-1 -> c=-1, z=-524288, reject=1, no writes. y[0]=3, cs1[0]=Q-2 -> z=1 written, no reject.
REQ-041 Pulse start while busy -> no restart and address sequence undisturbed. Assert rst at cycle T+100 -> we_z=0 from the next cycle, no done; a following start -> complete clean pass.
REQ-042 y[0]=524288, cs1[0]=4190208 -> s=4714496, reduced z=-3665921, reject=1.

Source files
------------

// File: rtl/z_norm_check.sv
// Streams y and c*s1 from two BRAMs, forms z = y + centred(c*s1) mod+- Q, and writes z
// while |z| stays below gamma1 - BETA; the first violation aborts the pass with reject set.
module z_norm_check #(
  parameter int L      = 7,
  parameter int N      = 256,
  parameter int GAMMA1 = 19,
  parameter int BETA   = 120,
  parameter int Q      = 8380417
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       reject,
  output logic [$clog2(N*L)-1:0]     rd_addr,
  input  logic [23:0]                dout_y,
  input  logic [22:0]                dout_cs1,
  output logic                       we_z,
  output logic [$clog2(N*L)-1:0]     addr_z,
  output logic [23:0]                din_z
);

  localparam int AW = $clog2(N*L);
  localparam int SW = 26;
  localparam logic [AW-1:0]        LAST  = AW'(N*L-1);
  localparam logic signed [SW-1:0] QS    = SW'(Q);
  localparam logic signed [SW-1:0] HALF  = SW'((Q-1)/2);
  localparam logic signed [SW-1:0] BOUND = SW'((1 << GAMMA1) - BETA);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t state, state_nx;

  logic                 rd_vld;   // dout_* carries data for rd_addr_q this cycle
  logic [AW-1:0]        rd_addr_q;
  logic                 live;
  logic                 viol;
  logic signed [SW-1:0] c_w, s_w, z_w, mag;

  assign busy = (state != IDLE);
  assign done = (state == FIN);

  // Data arriving in FIN belongs to reads issued before an abort and is dropped.
  assign live = rd_vld && ((state == RUN) || (state == DRAIN));

  always_comb begin
    c_w = $signed({3'b000, dout_cs1});
    if (c_w > HALF) c_w = c_w - QS;
    s_w = $signed({{2{dout_y[23]}}, dout_y}) + c_w;
    if (s_w > HALF)       z_w = s_w - QS;
    else if (s_w < -HALF) z_w = s_w + QS;
    else                  z_w = s_w;
    mag  = z_w[SW-1] ? -z_w : z_w;
    viol = live && (mag >= BOUND);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN:   if (viol) state_nx = FIN;
             else if (rd_addr == LAST) state_nx = DRAIN;
      DRAIN: if (viol) state_nx = FIN;
             else if (we_z && (addr_z == LAST)) state_nx = FIN;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr   <= '0;
      rd_addr_q <= '0;
      rd_vld    <= 1'b0;
      reject    <= 1'b0;
      we_z      <= 1'b0;
      addr_z    <= '0;
      din_z     <= '0;
    end else begin
      we_z      <= 1'b0;
      rd_vld    <= (state == RUN) && !viol;
      rd_addr_q <= rd_addr;
      if ((state == IDLE) && start) begin
        rd_addr <= '0;
        reject  <= 1'b0;
      end else if ((state == RUN) && !viol && (rd_addr != LAST)) begin
        rd_addr <= rd_addr + AW'(1);
      end
      if (live) begin
        if (viol) begin
          reject <= 1'b1;
        end else begin
          we_z   <= 1'b1;
          addr_z <= rd_addr_q;
          din_z  <= z_w[23:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_z_norm_check.sv
// Randomized and directed passes of z_norm_check against an arithmetic reference model
// of the centring, reduction and norm-bound rules, including abort and reset scenarios.
module tb_z_norm_check;
  localparam int L = 7, N = 256, GAMMA1 = 19, BETA = 120, Q = 8380417;
  localparam int NL = N * L;
  localparam int AW = $clog2(NL);
  localparam longint H = (Q - 1) / 2;
  localparam longint B = (64'sd1 << GAMMA1) - BETA;

  logic clk = 1'b0;
  logic rst, start, busy, done, reject, we_z;
  logic [AW-1:0] rd_addr, addr_z;
  logic [23:0] dout_y, din_z;
  logic [22:0] dout_cs1;

  always #5 clk = ~clk;

  z_norm_check #(.L(L), .N(N), .GAMMA1(GAMMA1), .BETA(BETA), .Q(Q)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .reject(reject),
    .rd_addr(rd_addr), .dout_y(dout_y), .dout_cs1(dout_cs1),
    .we_z(we_z), .addr_z(addr_z), .din_z(din_z)
  );

  logic [23:0] y_mem  [NL];
  logic [22:0] cs_mem [NL];

  always @(posedge clk) begin
    dout_y   <= y_mem[rd_addr];
    dout_cs1 <= cs_mem[rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_cyc[$], wr_addr[$], wr_data[$];
  int done_cnt = 0, done_cyc = 0;

  always @(posedge clk) begin
    #1;
    if (we_z === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(int'(addr_z));
      wr_data.push_back(int'($signed(din_z)));
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_z(input int i);
    longint y, c, s;
    y = longint'($signed(y_mem[i]));
    c = longint'(cs_mem[i]);
    if (c > H) c = c - Q;
    s = y + c;
    if (s > H) return s - Q;
    if (s < -H) return s + Q;
    return s;
  endfunction

  function automatic longint iabs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic fill_const(input int y, input int cs);
    for (int i = 0; i < NL; i++) begin
      y_mem[i]  = 24'(y);
      cs_mem[i] = 23'(cs);
    end
  endtask

  task automatic fill_rand(input int ymax, input int cmax);
    int yv, cv;
    for (int i = 0; i < NL; i++) begin
      yv = int'($urandom_range(2 * ymax)) - ymax;
      cv = int'($urandom_range(2 * cmax)) - cmax;
      y_mem[i]  = 24'(yv);
      cs_mem[i] = 23'((cv < 0) ? Q + cv : cv);
    end
  endtask

  task automatic clear_mon();
    wr_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  task automatic run_pass(input string name);
    longint exp_z[$];
    longint z;
    int T, n;
    bit rej;
    rej = 1'b0;
    for (int i = 0; i < NL; i++) begin
      z = ref_z(i);
      if (iabs(z) >= B) begin
        rej = 1'b1;
        break;
      end
      exp_z.push_back(z);
    end
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    T = cyc;
    @(negedge clk);
    start = 1'b0;
    chk({name, " reject cleared on start"}, reject, 0);
    for (int k = 0; k < NL + 20 && done_cnt == 0; k++) @(negedge clk);
    repeat (6) @(negedge clk);
    chk({name, " done pulses"}, done_cnt, 1);
    chk({name, " done cycle"}, done_cyc, T + exp_z.size() + 3);
    chk({name, " write count"}, wr_addr.size(), exp_z.size());
    n = (wr_addr.size() < exp_z.size()) ? wr_addr.size() : exp_z.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s addr[%0d]", name, i), wr_addr[i], i);
      chk($sformatf("%s z[%0d]", name, i), wr_data[i], exp_z[i]);
      chk($sformatf("%s wcyc[%0d]", name, i), wr_cyc[i], T + 3 + i);
    end
    chk({name, " reject held"}, reject, rej);
    chk({name, " busy idle"}, busy, 0);
  endtask

  initial begin
    int T;
    rst = 1'b1;
    start = 1'b0;
    fill_const(0, 0);
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst reject", reject, 0);
    chk("rst we_z", we_z, 0);
    chk("rst rd_addr", rd_addr, 0);
    chk("rst addr_z", addr_z, 0);
    chk("rst din_z", din_z, 0);
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst beats start", busy, 0);

    run_pass("zeros");

    fill_const(0, 0);
    y_mem[5] = 24'(524168);
    run_pass("viol at 5");

    fill_const(524167, 0);
    run_pass("max pos");
    fill_const(-524167, 0);
    run_pass("max neg");

    fill_const(0, 0);
    y_mem[0] = 24'(-524287);
    cs_mem[0] = 23'(Q - 1);
    run_pass("viol at 0");
    fill_const(0, 0);
    y_mem[0] = 24'(3);
    cs_mem[0] = 23'(Q - 2);
    run_pass("centre -2");

    fill_const(0, 0);
    y_mem[0] = 24'(524288);
    cs_mem[0] = 23'(4190208);
    run_pass("wrap high");
    chk("wrap high ref", ref_z(0), -3665921);

    fill_rand(400000, 120000);
    run_pass("rand clean");
    fill_rand(300000, 230000);
    run_pass("rand edge");
    fill_rand(524287, 4190208);
    run_pass("rand full");
    fill_rand(200000, 100000);
    y_mem[$urandom_range(NL - 1)] = 24'(-524287);
    run_pass("rand planted");

    // start pulse while busy, then reset mid-pass
    fill_const(0, 0);
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    T = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < T + 50) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < T + 60) @(negedge clk);
    chk("busy mid", busy, 1);
    chk("rd_addr undisturbed", rd_addr, 59);
    while (cyc < T + 100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("we_z after rst", we_z, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst abort writes", wr_addr.size(), 98);
    chk("rst abort no done", done_cnt, 0);
    chk("rst abort busy", busy, 0);
    fill_rand(350000, 150000);
    run_pass("after rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: observed %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
